// File: rtl/frame_buffer_scanout.sv
`timescale 1ns/1ps
// frame_buffer_scanout
// Reads the stored frame buffer in raster order and streams palette indices
// downstream over valid/ready. Every stored pixel is repeated SCALE times
// horizontally and every stored line SCALE times vertically. A 3-entry FIFO
// absorbs the one-cycle synchronous read latency of the frame buffer.
//
// Ports:
//   CLK, RESET      clock, asynchronous active-high reset
//   Start           begin one frame scan (sampled only while idle)
//   fb_data         frame buffer read data, valid the cycle after read_address
//   ready           downstream accepts the current beat
//   read_address    frame buffer read address, y*H_RES + x
//   palette         palette index at the FIFO head
//   valid           palette/sof/eol/eof are meaningful
//   sof, eol, eof   first beat of frame, last beat of line, last beat of frame
//   Busy            scan in progress (state is not idle)
//   Done            one-cycle pulse after the last beat is accepted
module frame_buffer_scanout #(
  parameter int H_RES = 168,
  parameter int V_RES = 104,
  parameter int SCALE = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [4:0]  fb_data,
  input  logic        ready,
  output logic [14:0] read_address,
  output logic [4:0]  palette,
  output logic        valid,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        Busy,
  output logic        Done
);

  localparam int DATA_W = 5;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 3;
  localparam int ENT_W  = DATA_W + 3;
  localparam int XRW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW     = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW     = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [XRW-1:0] XR_MAX = XRW'(SCALE - 1);
  localparam logic [XW-1:0]  X_MAX  = XW'(H_RES - 1);
  localparam logic [YW-1:0]  Y_MAX  = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONES  = 2'd3
  } state_t;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  state_t state, state_next;

  logic [XRW-1:0] xr;
  logic [XW-1:0]  x;
  logic [XRW-1:0] yr;
  logic [YW-1:0]  y;

  logic           last_x, last_rep, final_rd;
  logic           sof_t, eol_t, eof_t;
  logic [2:0]     load;
  logic           issue;

  logic           inflight_p1;
  logic [2:0]     tags_p1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [1:0]     wr_ptr, rd_ptr, occ;
  logic           push, pop;
  logic [ENT_W-1:0] head;

  assign last_x   = (xr == XR_MAX) && (x == X_MAX);
  assign last_rep = last_x && (yr == XR_MAX);
  assign final_rd = last_rep && (y == Y_MAX);

  assign sof_t = (xr == '0) && (x == '0) && (yr == '0) && (y == '0);
  assign eol_t = last_x;
  assign eof_t = final_rd;

  // Slots already promised (stored + in flight) bound the issue; no pop lookahead.
  assign load  = {1'b0, occ} + {2'b0, inflight_p1};
  assign issue = (state == STREAM) && (load < 3'd3);

  // Counters hold after the final read so the address stays put through
  // Drain/DoneS; they are cleared on the way back to idle.
  assign read_address = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);

  // ---- stage p0: state and read counters (issue side)
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = STREAM;
      STREAM:  if (issue && final_rd) state_next = DRAIN;
      DRAIN:   if (!inflight_p1 && ((occ == 2'd0) || ((occ == 2'd1) && pop)))
                 state_next = DONES;
      DONES:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      xr <= '0;
      x  <= '0;
      yr <= '0;
      y  <= '0;
    end else if (state == DONES) begin
      xr <= '0;
      x  <= '0;
      yr <= '0;
      y  <= '0;
    end else if (issue && !final_rd) begin
      if (xr != XR_MAX) begin
        xr <= xr + XRW'(1);
      end else begin
        xr <= '0;
        if (x != X_MAX) begin
          x <= x + XW'(1);
        end else begin
          x <= '0;
          if (yr != XR_MAX) begin
            yr <= yr + XRW'(1);
          end else begin
            yr <= '0;
            y  <= y + YW'(1);
          end
        end
      end
    end
  end

  // ---- stage p1: read in flight, tags wait for fb_data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      inflight_p1 <= 1'b0;
    end else begin
      inflight_p1 <= issue;
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) begin
      tags_p1 <= {sof_t, eol_t, eof_t};
    end
  end

  // ---- stage p2: FIFO capture and head
  assign push = inflight_p1;
  assign pop  = valid && ready;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {tags_p1, fb_data};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Outputs are gated by valid so an empty FIFO (including after reset)
  // presents zeros regardless of stale storage contents.
  assign head    = mem[rd_ptr];
  assign valid   = (occ != 2'd0);
  assign palette = valid ? head[DATA_W-1:0] : '0;
  assign sof     = valid & head[DATA_W+2];
  assign eol     = valid & head[DATA_W+1];
  assign eof     = valid & head[DATA_W];

  assign Busy = (state != IDLE);
  assign Done = (state == DONES);

endmodule

// File: tb/tb_frame_buffer_scanout.sv
`timescale 1ns/1ps
// Directed bench for frame_buffer_scanout: a small 4x2 SCALE=2 instance for
// the functional scenarios and a 168-wide SCALE=3 instance (8 stored lines,
// to keep run time short) for the wide-line address sequence.
module tb_frame_buffer_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // small instance
  logic        start_s = 1'b0, ready_s = 1'b0;
  logic [4:0]  fbd_s = '0;
  logic [14:0] addr_s;
  logic [4:0]  pal_s;
  logic        valid_s, sof_s, eol_s, eof_s, busy_s, done_s;

  frame_buffer_scanout #(.H_RES(4), .V_RES(2), .SCALE(2)) dut_s (
    .CLK(clk), .RESET(rst), .Start(start_s), .fb_data(fbd_s), .ready(ready_s),
    .read_address(addr_s), .palette(pal_s), .valid(valid_s), .sof(sof_s),
    .eol(eol_s), .eof(eof_s), .Busy(busy_s), .Done(done_s)
  );

  // frame buffer preloaded with address & 31, one-cycle read latency
  always @(posedge clk) fbd_s <= addr_s[4:0];

  // wide instance
  logic        start_b = 1'b0, ready_b = 1'b0;
  logic [4:0]  fbd_b = '0;
  logic [14:0] addr_b;
  logic [4:0]  pal_b;
  logic        valid_b, sof_b, eol_b, eof_b, busy_b, done_b;

  frame_buffer_scanout #(.H_RES(168), .V_RES(8), .SCALE(3)) dut_b (
    .CLK(clk), .RESET(rst), .Start(start_b), .fb_data(fbd_b), .ready(ready_b),
    .read_address(addr_b), .palette(pal_b), .valid(valid_b), .sof(sof_b),
    .eol(eol_b), .eof(eof_b), .Busy(busy_b), .Done(done_b)
  );

  always @(posedge clk) fbd_b <= addr_b[4:0];

  // capture results of one small frame
  logic [4:0] cap_pal [64];
  bit         cap_sof [64];
  bit         cap_eol [64];
  bit         cap_eof [64];
  int nb, first_vld_cyc, last_beat_cyc, done_cnt, done_cyc, stall_bad, occ_bad, start_cyc;
  bit timeout, busy_after;

  function automatic logic [4:0] exp_pal_s(input int b);
    return 5'((b / 16) * 4 + (b % 8) / 2);
  endfunction

  function automatic int seq_errs();
    int e = 0;
    for (int b = 0; b < 32; b++) begin
      if (cap_pal[b] !== exp_pal_s(b)) e++;
      if (cap_sof[b] !== (b == 0)) e++;
      if (cap_eol[b] !== ((b % 8) == 7)) e++;
      if (cap_eof[b] !== (b == 31)) e++;
    end
    return e;
  endfunction

  function automatic int big_addr(input int k);
    int line;
    line = k / 504;
    return (line / 3) * 168 + (k % 504) / 3;
  endfunction

  // Runs one frame on the small instance: Start in cycle 0, ready with the
  // given duty (percent), optional Start pokes at beats 5 and 20.
  task automatic capture(input int rdy_pct, input bit poke);
    bit pv, pr, ps, pe, pf, fin;
    logic [4:0] pp;
    nb = 0; done_cnt = 0; stall_bad = 0; occ_bad = 0; timeout = 0;
    first_vld_cyc = -1; last_beat_cyc = -1; done_cyc = -1; busy_after = 1'b1;
    fin = 0; pv = 0; pr = 0; ps = 0; pe = 0; pf = 0; pp = '0;
    for (int i = 0; i < 64; i++) begin
      cap_pal[i] = '1; cap_sof[i] = 1; cap_eol[i] = 1; cap_eof[i] = 1;
    end
    @(posedge clk); #1;
    start_s = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (int'(dut_s.occ) + int'(dut_s.inflight_p1) > 3) occ_bad++;
      if (pv && !pr) begin
        if (!valid_s || pal_s !== pp || sof_s !== ps || eol_s !== pe || eof_s !== pf)
          stall_bad++;
      end
      if (done_s) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy_s;
      if (valid_s && first_vld_cyc < 0) first_vld_cyc = cyc;
      ready_s = ($urandom_range(99) < rdy_pct);
      if (poke) start_s = (nb == 5 || nb == 20);
      if (valid_s && ready_s) begin
        if (nb < 64) begin
          cap_pal[nb] = pal_s; cap_sof[nb] = sof_s; cap_eol[nb] = eol_s; cap_eof[nb] = eof_s;
        end
        last_beat_cyc = cyc;
        nb++;
      end
      pv = valid_s; pr = ready_s; pp = pal_s; ps = sof_s; pe = eol_s; pf = eof_s;
      if (done_cnt > 0 && cyc >= done_cyc + 3) begin fin = 1; break; end
      @(posedge clk); #1;
    end
    if (!fin) timeout = 1;
    ready_s = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic test_reset();
    // power-on reset values
    @(posedge clk); #1;
    n_tests++;
    if ({addr_s, pal_s, valid_s, sof_s, eol_s, eof_s, busy_s, done_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %h required 0",
               {addr_s, pal_s, valid_s, sof_s, eol_s, eof_s, busy_s, done_s});
    end
    rst = 1'b0;
    // start a frame, stall it, then reset mid-cycle
    @(posedge clk); #1;
    start_s = 1'b1; ready_s = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if ({valid_s, busy_s} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_prestate: valid/busy got %b required 11", {valid_s, busy_s});
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({addr_s, pal_s, valid_s, sof_s, eol_s, eof_s, busy_s, done_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h required 0",
               {addr_s, pal_s, valid_s, sof_s, eol_s, eof_s, busy_s, done_s});
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({busy_s, valid_s, addr_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: busy/valid/addr got %h required 0", {busy_s, valid_s, addr_s});
    end
  endtask

  task automatic test_free_run();
    int e;
    capture(100, 0);
    e = seq_errs();
    n_tests++;
    if (timeout) begin n_fail++; $display("FAIL free_timeout: got 1 required 0"); end
    n_tests++;
    if (nb !== 32) begin n_fail++; $display("FAIL free_beats: got %0d required 32", nb); end
    n_tests++;
    if (first_vld_cyc - start_cyc !== 3) begin
      n_fail++; $display("FAIL free_first_valid: got cycle %0d required 3", first_vld_cyc - start_cyc);
    end
    n_tests++;
    if (e !== 0) begin n_fail++; $display("FAIL free_sequence: got %0d errors required 0", e); end
    n_tests++;
    if (last_beat_cyc - first_vld_cyc !== 31) begin
      n_fail++; $display("FAIL free_no_bubbles: span got %0d required 31", last_beat_cyc - first_vld_cyc);
    end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL free_done_count: got %0d required 1", done_cnt); end
    n_tests++;
    if (done_cyc - last_beat_cyc !== 1) begin
      n_fail++; $display("FAIL free_done_timing: got %0d required 1", done_cyc - last_beat_cyc);
    end
    n_tests++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL free_idle_after_done: busy got 1 required 0"); end
  endtask

  task automatic test_backpressure();
    int e;
    capture(30, 0);
    e = seq_errs();
    n_tests++;
    if (nb !== 32 || timeout) begin
      n_fail++; $display("FAIL bp_beats: got %0d (timeout %0d) required 32", nb, timeout);
    end
    n_tests++;
    if (e !== 0) begin n_fail++; $display("FAIL bp_sequence: got %0d errors required 0", e); end
    n_tests++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d unstable required 0", stall_bad); end
    n_tests++;
    if (occ_bad !== 0) begin n_fail++; $display("FAIL bp_occupancy: got %0d over-3 cycles required 0", occ_bad); end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_start_busy();
    int e;
    capture(100, 1);
    e = seq_errs();
    n_tests++;
    if (nb !== 32 || timeout) begin
      n_fail++; $display("FAIL start_busy_beats: got %0d (timeout %0d) required 32", nb, timeout);
    end
    n_tests++;
    if (e !== 0) begin n_fail++; $display("FAIL start_busy_sequence: got %0d errors required 0", e); end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL start_busy_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_mid_reset();
    int e, k;
    k = 0;
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 0; c < 200; c++) begin
      ready_s = 1'b1;
      if (valid_s) k++;
      if (k == 10) break;
      @(posedge clk); #1;
    end
    n_tests++;
    if (k !== 10) begin n_fail++; $display("FAIL midrst_reach_beat10: got %0d required 10", k); end
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    ready_s = 1'b0;
    n_tests++;
    if ({valid_s, busy_s} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_cleared: valid/busy got %b required 00", {valid_s, busy_s});
    end
    capture(100, 0);
    e = seq_errs();
    n_tests++;
    if (cap_pal[0] !== 5'd0 || cap_sof[0] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_first_beat: pal %0d sof %0d required 0 1", cap_pal[0], cap_sof[0]);
    end
    n_tests++;
    if (nb !== 32 || e !== 0) begin
      n_fail++; $display("FAIL midrst_frame: beats %0d errors %0d required 32 0", nb, e);
    end
  endtask

  task automatic test_full_frame();
    int nbeat, ni, aerr, perr, terr, eols, eof_at, n_last;
    bit got_done;
    logic [14:0] addr_done, addr_idle;
    nbeat = 0; ni = 0; aerr = 0; perr = 0; terr = 0; eols = 0; eof_at = -1; n_last = 0;
    got_done = 0; addr_done = '0; addr_idle = '1;
    @(posedge clk); #1;
    start_b = 1'b1; ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (dut_b.issue) begin
        if (int'(addr_b) !== big_addr(ni)) aerr++;
        if (addr_b == 15'd1343) n_last++;
        ni++;
      end
      if (valid_b) begin
        if (pal_b !== 5'(big_addr(nbeat))) perr++;
        if (sof_b !== (nbeat == 0)) terr++;
        if (eol_b !== ((nbeat % 504) == 503)) terr++;
        if (eol_b) eols++;
        if (eof_b) eof_at = nbeat;
        nbeat++;
      end
      if (done_b) begin got_done = 1; addr_done = addr_b; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    addr_idle = addr_b;
    ready_b = 1'b0;
    n_tests++;
    if (!got_done || nbeat !== 12096) begin
      n_fail++; $display("FAIL full_beats: got %0d (done %0d) required 12096", nbeat, got_done);
    end
    n_tests++;
    if (ni !== 12096 || aerr !== 0) begin
      n_fail++; $display("FAIL full_addresses: issues %0d errors %0d required 12096 0", ni, aerr);
    end
    n_tests++;
    if (perr !== 0 || terr !== 0) begin
      n_fail++; $display("FAIL full_data: pal errors %0d tag errors %0d required 0 0", perr, terr);
    end
    n_tests++;
    if (n_last !== 9) begin n_fail++; $display("FAIL full_last_addr_count: got %0d required 9", n_last); end
    n_tests++;
    if (eof_at !== 12095 || eols !== 24) begin
      n_fail++; $display("FAIL full_eof_eol: eof at %0d eols %0d required 12095 24", eof_at, eols);
    end
    n_tests++;
    if (addr_done !== 15'd1343) begin n_fail++; $display("FAIL full_addr_hold: got %0d required 1343", addr_done); end
    n_tests++;
    if (addr_idle !== 15'd0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL full_idle: addr %0d busy %0d required 0 0", addr_idle, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_start_busy();
    test_mid_reset();
    test_full_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_scanout.md
# frame_buffer_scanout

Reads the 168x104, 5-bit-palette frame buffer in raster order and streams palette indices to the display path over a valid/ready handshake. It is the read-side counterpart of the sprite-to-frame-buffer writer. Each stored pixel is replicated SCALE times horizontally and each stored line SCALE times vertically. The block absorbs the frame buffer's 1-cycle synchronous read latency with a 3-entry output FIFO, so it sustains one beat per cycle under continuous ready.

## Interface

Parameters:
- H_RES, 168: stored pixels per line.
- V_RES, 104: stored lines per frame.
- SCALE, 3: replication factor in both axes, 1..4.

Ports:
- CLK, input, 1: single clock; all state on rising edge.
- RESET, input, 1: asynchronous, active-high; clears all state.
- Start, input, 1: begin one frame scan; sampled in Idle only.
- fb_data, input, 5: frame buffer data_Out; valid the cycle after read_address is presented.
- ready, input, 1: downstream accepts the current beat.
- read_address, output, 15: frame buffer read address, equal to y*H_RES + x.
- palette, output, 5: FIFO head palette index.
- valid, output, 1: palette/sof/eol/eof are meaningful.
- sof, output, 1: first beat of frame.
- eol, output, 1: last beat of an output line.
- eof, output, 1: last beat of frame.
- Busy, output, 1: state is not Idle.
- Done, output, 1: one-cycle pulse after the last beat is accepted.

## Operation

- **States:**
  - Idle, Stream, Drain, DoneS.
  - Idle -> Stream on Start.
  - Stream -> Drain when the final read is issued.
  - Drain -> DoneS when the FIFO is empty and nothing is in flight.
  - DoneS -> Idle unconditionally.
- **Read counters:**
  - xr: 0..SCALE-1, innermost.
  - x: 0..H_RES-1.
  - yr: 0..SCALE-1.
  - y: 0..V_RES-1, outermost.
  - Counters advance only on an issue. Each output beat is exactly one read.
- **Issue rule:**
  - Issue in Stream when occ + inflight < 3, where occ is registered FIFO occupancy 0..3 and inflight is registered 0/1.
  - No pop lookahead.
  - Issue sets inflight for the next cycle.
  - Data is captured into the FIFO at the end of the cycle after issue.
- **Sideband:** sof/eol/eof tags are computed from the counters at issue and travel with the data through the FIFO.
- **Pop:** occurs when valid && ready.
- **read_address:**
  - Computed combinationally from the current x and y, 15-bit unsigned.
  - Maximum 17471 at defaults; no overflow.
  - Held at its last value outside Stream.
  - 0 in Idle.
- **Start handling:** Start in any state other than Idle is ignored; the current frame continues unaffected.
- **Stall behaviour:** while valid && !ready, palette, sof, eol and eof are held stable.
- **Simultaneous events:** capture and pop in the same cycle leave occ unchanged.
- **Reset:**
  - RESET at any time, including mid-frame, returns to Idle on the edge.
  - FIFO and inflight are emptied, counters are zeroed, and any in-flight fb_data is discarded.
- **Reset values:** read_address=0, palette=0, valid=0, sof=0, eol=0, eof=0, Busy=0, Done=0.

## Timing

- Start is high in cycle 0 while Idle:
  - Stream begins in cycle 1.
  - First issue is in cycle 1.
  - Data is captured at the end of cycle 2.
  - First valid is in cycle 3.
- With ready held high from cycle 3, one beat per cycle with no bubbles until eof.
- Total beats per frame: H_RES*SCALE*V_RES*SCALE, which is 157248 at defaults.
- Done:
  - eof is accepted in cycle N, then Drain completes.
  - DoneS and Done=1 occur in cycle N+1.
  - Idle is reached in cycle N+2.
  - A new Start is accepted in cycle N+2.
- Busy is high from cycle 1 through the DoneS cycle inclusive.
- FIFO never overflows: occ + inflight <= 3 at all times.

## Test plan

- **Reset:** assert RESET asynchronously mid-cycle -> all outputs 0 immediately; state Idle.
- **Small frame, free-running:**
  - Setup: H_RES=4, V_RES=2, SCALE=2; frame buffer preloaded with address&31; Start, ready=1.
  - Required: valid first in cycle 3; 32 beats, one per cycle.
  - Palette sequence: 0,0,1,1,2,2,3,3 twice, then 4,4,5,5,6,6,7,7 twice.
  - Tags: sof on beat 0, eol every 8th beat, eof on beat 31.
  - Done pulses exactly one cycle, one cycle after beat 31.
- **Backpressure:**
  - Stimulus: same frame with ready driven by pseudo-random 30% duty.
  - Required: identical 32-beat sequence with no loss or duplication; outputs stable during stalls; occ + inflight never exceeds 3.
- **Start while busy:** pulse Start at beats 5 and 20 -> ignored; exactly 32 beats and one Done.
- **Mid-frame reset, then restart:**
  - Stimulus: RESET at beat 10, then Start.
  - Required: the new frame begins at palette 0 with sof; no stale beats.
- **Default parameters, full frame, ready=1:**
  - Required: 157248 beats.
  - Final read_address is 17471, and it is issued 3 consecutive times for each of the last 3 output lines.
  - eof coincides with the last of these beats.
